// File: rtl/timer_pkg.sv
// timer_pkg: shared field widths, preset limits and FSM encoding for the countdown timers.
package timer_pkg;
  localparam int MIN_W = 7;
  localparam int SEC_W = 6;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 7'd99;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_ALARM = 2'd3;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler counting 0..CYCLES-1 while enabled, tick on the terminal count.
module tick_gen #(
  parameter int CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = CYCLES > 1 ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] TC = W'(CYCLES - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = en && cnt_q == TC;
  always_comb cnt_d = (clr || tick) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/countdown_alarm_ctrl.sv
// countdown_alarm_ctrl: mm:ss countdown with pause/resume and a timed, acknowledgeable alarm.
module countdown_alarm_ctrl
  import timer_pkg::*;
#(
  parameter int CRYSTAL_FREQUENCY = 50_000_000,
  parameter int ALARM_SECONDS     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [MIN_W-1:0] load_min,
  input  logic [SEC_W-1:0] load_sec,
  output logic [MIN_W-1:0] min_out,
  output logic [SEC_W-1:0] sec_out,
  output logic             running,
  output logic             flash_en,
  output logic             done
);
  localparam int AW = $clog2(ALARM_SECONDS + 1);
  logic [1:0] state_q, state_d;
  logic [MIN_W-1:0] min_q, min_d, min_dec;
  logic [SEC_W-1:0] sec_q, sec_d, sec_dec;
  logic [AW-1:0] acnt_q, acnt_d;
  logic running_q, running_d, flash_q, flash_d, done_q, done_d;
  logic tick, load, expire;
  assign load = state_q == S_IDLE && start && !stop && (load_min != '0 || load_sec != '0);
  tick_gen #(.CYCLES(CRYSTAL_FREQUENCY)) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (state_q == S_RUN || state_q == S_ALARM),
    .clr (load),
    .tick(tick)
  );
  always_comb begin
    sec_dec = sec_q != '0 ? sec_q - 1'b1 : min_q != '0 ? SEC_MAX : '0;
    min_dec = (sec_q == '0 && min_q != '0) ? min_q - 1'b1 : min_q;
    expire  = tick && min_dec == '0 && sec_dec == '0;
  end
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    acnt_d  = acnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (load) begin
        state_d = S_RUN;
        min_d   = load_min > MIN_MAX ? MIN_MAX : load_min;
        sec_d   = load_sec > SEC_MAX ? SEC_MAX : load_sec;
      end
      S_RUN: begin
        if (tick) begin
          min_d = min_dec;
          sec_d = sec_dec;
        end
        // reaching 00:00 takes precedence over a pause on the same edge
        if (expire) begin
          state_d = S_ALARM;
          done_d  = 1'b1;
          acnt_d  = '0;
        end else if (stop) state_d = S_PAUSE;
      end
      S_PAUSE: if (stop) begin
        state_d = S_IDLE;
        min_d   = '0;
        sec_d   = '0;
      end else if (start) state_d = S_RUN;
      default: if (start || stop) state_d = S_IDLE;
      else if (tick) begin
        acnt_d  = acnt_q + 1'b1;
        state_d = acnt_q == AW'(ALARM_SECONDS - 1) ? S_IDLE : S_ALARM;
      end
    endcase
    running_d = state_d == S_RUN;
    // flash trails the ALARM entry by one cycle but drops on the acknowledge edge
    flash_d   = state_q == S_ALARM && !(start || stop);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= S_IDLE;
      min_q     <= '0;
      sec_q     <= '0;
      acnt_q    <= '0;
      running_q <= 1'b0;
      flash_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      acnt_q    <= acnt_d;
      running_q <= running_d;
      flash_q   <= flash_d;
      done_q    <= done_d;
    end
  assign min_out  = min_q;
  assign sec_out  = sec_q;
  assign running  = running_q;
  assign flash_en = flash_q;
  assign done     = done_q;
endmodule

// File: tb/tb_countdown_alarm_ctrl.sv
// tb_countdown_alarm_ctrl: scenario tasks queue expected output vectors per cycle and compare them as cycles elapse.
module tb_countdown_alarm_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic [6:0] load_min = '0;
  logic [5:0] load_sec = '0;
  logic [6:0] min_out;
  logic [5:0] sec_out;
  logic running, flash_en, done;
  logic [15:0] obs;
  int tests = 0;
  int failed = 0;
  typedef struct {
    int t;
    logic [15:0] v;
    string name;
  } exp_t;
  exp_t sb[$];
  countdown_alarm_ctrl #(.CRYSTAL_FREQUENCY(10), .ALARM_SECONDS(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .load_min(load_min),
    .load_sec(load_sec),
    .min_out (min_out),
    .sec_out (sec_out),
    .running (running),
    .flash_en(flash_en),
    .done    (done)
  );
  always #5 clk = ~clk;
  assign obs = {min_out, sec_out, running, flash_en, done};
  function automatic void expect_at(int t, logic [6:0] mn, logic [5:0] sc, logic r, logic f, logic d, string n);
    exp_t e;
    e.t = t;
    e.v = {mn, sc, r, f, d};
    e.name = n;
    sb.push_back(e);
  endfunction
  task automatic test_reset();
    exp_t e;
    expect_at(0, 0, 0, 0, 0, 0, "reset_state");
    expect_at(2, 0, 0, 0, 0, 0, "idle_after_reset");
    for (int t = 0; t <= 2; t++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].t == t) begin
        e = sb.pop_front(); tests++;
        if (obs !== e.v) begin failed++; $display("FAIL %s t=%0d got %h expected %h", e.name, t, obs, e.v); end
      end
      if (t == 0) rst = 1'b0;
    end
  endtask
  task automatic test_expire();
    exp_t e;
    expect_at(0, 0, 2, 1, 0, 0, "load_0002");
    expect_at(9, 0, 2, 1, 0, 0, "before_tick1");
    expect_at(10, 0, 1, 1, 0, 0, "tick1");
    expect_at(19, 0, 1, 1, 0, 0, "before_tick2");
    expect_at(20, 0, 0, 0, 0, 1, "done_pulse");
    expect_at(21, 0, 0, 0, 1, 0, "flash_on");
    expect_at(35, 0, 0, 0, 1, 0, "flash_mid");
    expect_at(50, 0, 0, 0, 1, 0, "flash_last");
    expect_at(51, 0, 0, 0, 0, 0, "flash_off");
    load_min = 0; load_sec = 2; start = 1'b1;
    for (int t = 0; t <= 52; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      while (sb.size() > 0 && sb[0].t == t) begin
        e = sb.pop_front(); tests++;
        if (obs !== e.v) begin failed++; $display("FAIL %s t=%0d got %h expected %h", e.name, t, obs, e.v); end
      end
    end
  endtask
  task automatic test_minute_borrow();
    exp_t e;
    expect_at(0, 1, 0, 1, 0, 0, "load_0100");
    expect_at(9, 1, 0, 1, 0, 0, "hold_0100");
    expect_at(10, 0, 59, 1, 0, 0, "borrow_0059");
    expect_at(11, 0, 59, 0, 0, 0, "pause_0059");
    expect_at(12, 0, 0, 0, 0, 0, "clear_from_pause");
    load_min = 1; load_sec = 0; start = 1'b1;
    for (int t = 0; t <= 12; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      while (sb.size() > 0 && sb[0].t == t) begin
        e = sb.pop_front(); tests++;
        if (obs !== e.v) begin failed++; $display("FAIL %s t=%0d got %h expected %h", e.name, t, obs, e.v); end
      end
      stop = (t == 10 || t == 11);
    end
  endtask
  task automatic test_pause_resume();
    exp_t e;
    expect_at(0, 0, 5, 1, 0, 0, "load_0005");
    expect_at(10, 0, 4, 1, 0, 0, "tick_ignores_start_and_preset");
    expect_at(15, 0, 4, 0, 0, 0, "paused");
    expect_at(114, 0, 4, 0, 0, 0, "pause_held");
    expect_at(115, 0, 4, 1, 0, 0, "resumed");
    expect_at(119, 0, 4, 1, 0, 0, "resume_before_tick");
    expect_at(120, 0, 3, 1, 0, 0, "resume_tick");
    expect_at(121, 0, 3, 0, 0, 0, "pause_again");
    expect_at(122, 0, 0, 0, 0, 0, "cleared");
    load_min = 0; load_sec = 5; start = 1'b1;
    for (int t = 0; t <= 122; t++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].t == t) begin
        e = sb.pop_front(); tests++;
        if (obs !== e.v) begin failed++; $display("FAIL %s t=%0d got %h expected %h", e.name, t, obs, e.v); end
      end
      if (t == 0) load_sec = 40;
      start = (t == 2 || t == 114);
      stop = (t == 14 || t == 120 || t == 121);
    end
  endtask
  task automatic test_simultaneous();
    exp_t e;
    expect_at(0, 0, 0, 0, 0, 0, "idle_both_ignored");
    expect_at(5, 0, 0, 0, 0, 0, "idle_stays");
    expect_at(6, 0, 5, 1, 0, 0, "load_0005");
    expect_at(8, 0, 5, 0, 0, 0, "run_both_pauses");
    expect_at(9, 0, 0, 0, 0, 0, "clear");
    expect_at(10, 0, 0, 0, 0, 0, "stop_in_idle");
    load_min = 0; load_sec = 5; start = 1'b1; stop = 1'b1;
    for (int t = 0; t <= 10; t++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].t == t) begin
        e = sb.pop_front(); tests++;
        if (obs !== e.v) begin failed++; $display("FAIL %s t=%0d got %h expected %h", e.name, t, obs, e.v); end
      end
      start = (t == 5 || t == 7);
      stop = (t == 7 || t == 8 || t == 9);
    end
  endtask
  task automatic test_zero_clamp();
    exp_t e;
    expect_at(0, 0, 0, 0, 0, 0, "zero_preset_ignored");
    expect_at(3, 0, 0, 0, 0, 0, "zero_stays_idle");
    expect_at(4, 0, 59, 1, 0, 0, "sec_clamp");
    expect_at(5, 0, 59, 0, 0, 0, "sec_clamp_pause");
    expect_at(6, 0, 0, 0, 0, 0, "sec_clamp_clear");
    expect_at(7, 99, 0, 1, 0, 0, "min_clamp");
    expect_at(16, 99, 0, 1, 0, 0, "min_clamp_hold");
    expect_at(17, 98, 59, 1, 0, 0, "min_clamp_borrow");
    expect_at(18, 98, 59, 0, 0, 0, "min_clamp_pause");
    expect_at(19, 0, 0, 0, 0, 0, "min_clamp_clear");
    load_min = 0; load_sec = 0; start = 1'b1;
    for (int t = 0; t <= 19; t++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].t == t) begin
        e = sb.pop_front(); tests++;
        if (obs !== e.v) begin failed++; $display("FAIL %s t=%0d got %h expected %h", e.name, t, obs, e.v); end
      end
      if (t == 3) load_sec = 63;
      if (t == 6) begin load_min = 120; load_sec = 0; end
      start = (t == 3 || t == 6);
      stop = (t == 4 || t == 5 || t == 17 || t == 18);
    end
  endtask
  task automatic test_alarm_ack();
    exp_t e;
    expect_at(10, 0, 0, 0, 0, 1, "ack_done");
    expect_at(11, 0, 0, 0, 1, 0, "ack_flash");
    expect_at(12, 0, 0, 0, 1, 0, "ack_flash_held");
    expect_at(13, 0, 0, 0, 0, 0, "ack_start_to_idle");
    expect_at(14, 0, 0, 0, 0, 0, "ack_no_reload");
    load_min = 0; load_sec = 1; start = 1'b1;
    for (int t = 0; t <= 14; t++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].t == t) begin
        e = sb.pop_front(); tests++;
        if (obs !== e.v) begin failed++; $display("FAIL %s t=%0d got %h expected %h", e.name, t, obs, e.v); end
      end
      start = (t == 12);
    end
  endtask
  task automatic test_reset_mid_alarm();
    exp_t e;
    expect_at(11, 0, 0, 0, 1, 0, "pre_reset_flash");
    expect_at(16, 0, 0, 0, 0, 0, "reset_held");
    expect_at(17, 0, 0, 0, 0, 0, "reset_held2");
    expect_at(18, 0, 1, 1, 0, 0, "first_cmd_after_reset");
    expect_at(19, 0, 1, 1, 0, 0, "no_done_after_release");
    expect_at(28, 0, 0, 0, 0, 1, "done_after_new_run");
    load_min = 0; load_sec = 1; start = 1'b1;
    for (int t = 0; t <= 30; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      while (sb.size() > 0 && sb[0].t == t) begin
        e = sb.pop_front(); tests++;
        if (obs !== e.v) begin failed++; $display("FAIL %s t=%0d got %h expected %h", e.name, t, obs, e.v); end
      end
      if (t == 15) begin
        rst = 1'b1;
        #1;
        tests++;
        if (obs !== 16'h0) begin failed++; $display("FAIL async_reset t=%0d got %h expected %h", t, obs, 16'h0); end
      end
      if (t == 17) begin rst = 1'b0; start = 1'b1; end
    end
  endtask
  initial begin
    test_reset();
    test_expire();
    test_minute_borrow();
    test_pause_resume();
    test_simultaneous();
    test_zero_clamp();
    test_alarm_ack();
    test_reset_mid_alarm();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
